ad7606_emu: RTL and testbench
=============================

# ad7606_emu

Synthesizable device-side emulator of the AD7606 parallel interface, for hardware-in-the-loop checking of the AD7606 controller on the CPLD/FPGA without a real converter. It responds to CONVST A/B, drives BUSY for a programmable conversion time scaled by the oversampling setting, and serves eight 16-bit channel words on the parallel bus under CS/RD control with FRSTDATA marking channel 1. Sample values come either from an external 8×16 bus or from an internal deterministic pattern.

## Interface
Parameters:
- `CONV_CYCLES`, default 32: clk cycles of BUSY per conversion at `os = 0`.
- `BUSY_DLY`, default 2: clk cycles from detected CONVST fall to BUSY rise (min 1).
- `PATTERN`, default 1: 1 = internal pattern source; 0 = `sample_in`.

Ports:
- `clk` in 1: emulator clock; must be ≥4× the controller clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `convst_a`, `convst_b` in 1: conversion start, asynchronous to `clk`.
- `cs_n`, `rd_n` in 1: chip select and read strobe, asynchronous.
- `phy_rst` in 1: device reset, active high, asynchronous.
- `os` in 3: oversampling ratio select.
- `sample_in` in 128: ch1 = [15:0] … ch8 = [127:112], used when `PATTERN = 0`.
- `busy` out 1: conversion in progress.
- `frstdata` out 1: high while the channel-1 word is driven.
- `db` out 16: data bus.
- `db_oe` out 1: bus drive enable (`!cs_n_s && !rd_n_s`).
- `conv_cnt` out 16: completed-conversion count.
- `overrun` out 1: sticky flag; CONVST fell while busy or in the delay window. Cleared by `phy_rst`.

## Operation
- Input synchronization: `convst_a`, `convst_b`, `cs_n`, `rd_n` and `phy_rst` each pass through a 2-FF synchronizer (`_s` suffix). A start is the `_s` transition of `(convst_a & convst_b)` from 1 to 0.
- FSM states:
  - IDLE: on start, snapshot the sample source into the pending bank and go to DLY.
  - DLY: wait `BUSY_DLY` cycles, then go to CONV with `busy = 1`.
  - CONV: wait `CONV_CYCLES << os_eff` cycles, then go to DONE. `os_eff = os` for 0–6; `os = 7` is treated as 0.
  - DONE: for one cycle, copy pending to the output bank, clear the read pointer, set `busy = 0`, increment `conv_cnt` (wraps at 0xFFFF), then return to IDLE.
- A start seen in DLY or CONV is ignored and sets `overrun`.
- `os` is sampled at the start event and held for that conversion.
- Pattern source: channel k (k = 0..7) = `{conv_cnt[11:0], k[3:0]}`, taken at snapshot time.
- Reads:
  - While `cs_n_s = 0`, each `rd_n_s` fall drives `db = out_bank[ptr]` and `frstdata = (ptr == 0)`.
  - Each `rd_n_s` rise increments `ptr` mod 8; the 9th read returns ch1 again with `frstdata` high.
  - The `cs_n_s` rise leaves `ptr` unchanged.
- Reads during DLY/CONV return the previous output bank and are legal. A new bank becomes visible only in DONE.
- If DONE coincides with an `rd_n_s` rise, DONE wins: `ptr = 0`.
- `phy_rst_s = 1`, at any state:
  - Go to IDLE, `busy = 0`, `ptr = 0`.
  - Clear both banks, `conv_cnt` and `overrun`.
  - Starts are ignored while it is high.
- `db` holds its last value when `db_oe = 0`. `frstdata` clears when `db_oe` falls.

## Timing
- Reset values: `busy = 0`, `frstdata = 0`, `db = 0`, `db_oe = 0`, `conv_cnt = 0`, `overrun = 0`, state IDLE, `ptr = 0`, both banks 0.
- Pin CONVST fall to `busy` rise: 2 + 1 + `BUSY_DLY` clk cycles.
- `busy` high for exactly `CONV_CYCLES << os_eff` cycles.
- Pin `rd_n` fall to `db`/`frstdata` valid: 3 cycles. Pin `rd_n` rise to `ptr` advance: 3 cycles.
- All outputs are registered.

## Structure
- Shared package `ad7606_pkg`: channel count (8), word width (16), FSM state enum, `OS_MAX = 6`.
- One sub-module `sync2` (2-FF synchronizer, parameterized reset value), instantiated 5 times. Reset values: 1 for `convst_a`, `convst_b`, `cs_n`, `rd_n`; 0 for `phy_rst`.

## Test plan
- Reset, then one CONVST pulse with `os = 0`, `PATTERN = 1` → `busy` high 32 cycles; 8 reads return 0x0000, 0x0001 … 0x0007; `frstdata` only on the first; `conv_cnt = 1`.
- Second conversion with `os = 2` → `busy` high 128 cycles; reads return 0x0010 … 0x0017.
- CONVST pulse during CONV → `busy` length unchanged, `overrun = 1`, `conv_cnt` increments once.
- `PATTERN = 0`, `sample_in` ch k = 0xA000 + k; 10 reads → 0xA000 … 0xA007, then 0xA000 (`frstdata = 1`) and 0xA001.
- Read ch1–ch3, then start a new conversion and read during CONV → returns old ch4; after DONE, the next read returns new ch1.
- `phy_rst` pulse mid-CONV → `busy = 0` within 3 cycles, reads return 0x0000, `conv_cnt = 0`, `overrun = 0`.

Source files
------------

// File: rtl/ad7606_pkg.sv
// Shared definitions for the AD7606 device emulator: bus geometry, FSM states,
// oversampling limits and the effective-oversampling helper.
package ad7606_pkg;

  localparam int unsigned NUM_CH  = 8;
  localparam int unsigned WORD_W  = 16;
  localparam int unsigned PTR_W   = 3;
  localparam int unsigned OS_W    = 3;
  localparam int unsigned OS_MAX  = 6;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned CCNT_W  = 16;
  localparam int unsigned BANK_W  = NUM_CH * WORD_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DLY,
    ST_CONV,
    ST_DONE
  } state_e;

  // Channel 1 lives in the least significant word.
  typedef logic [NUM_CH-1:0][WORD_W-1:0] bank_t;

  // Oversampling codes above OS_MAX behave as no oversampling.
  function automatic logic [OS_W-1:0] os_eff(input logic [OS_W-1:0] os);
    return (32'(os) > OS_MAX) ? OS_W'(0) : os;
  endfunction

endpackage

// File: rtl/ad7606_emu_sync2.sv
// Two-flop synchronizer with a selectable reset level.
// Ports: clk, rst_n (async, active-low), d_i (asynchronous input),
//        q_o (synchronized output).
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      q_o    <= RST_VAL;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/ad7606_emu.sv
// AD7606 parallel-interface device emulator for controller hardware-in-the-loop.
// Ports: clk, rst_n (async, active-low); convst_a/convst_b, cs_n, rd_n, phy_rst
//        (asynchronous pins); os (oversampling select); sample_in (8x16 external
//        samples, ch1 in [15:0]); busy, frstdata, db, db_oe, conv_cnt, overrun
//        (all registered).
module ad7606_emu
  import ad7606_pkg::*;
#(
  parameter int unsigned CONV_CYCLES = 32,
  parameter int unsigned BUSY_DLY    = 2,
  parameter int unsigned PATTERN     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              convst_a,
  input  logic              convst_b,
  input  logic              cs_n,
  input  logic              rd_n,
  input  logic              phy_rst,
  input  logic [OS_W-1:0]   os,
  input  logic [BANK_W-1:0] sample_in,
  output logic              busy,
  output logic              frstdata,
  output logic [WORD_W-1:0] db,
  output logic              db_oe,
  output logic [CCNT_W-1:0] conv_cnt,
  output logic              overrun
);

  logic convst_a_s, convst_b_s, cs_n_s, rd_n_s, phy_rst_s;

  sync2 #(.RST_VAL(1'b1)) u_sync_cva (.clk(clk), .rst_n(rst_n), .d_i(convst_a), .q_o(convst_a_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_cvb (.clk(clk), .rst_n(rst_n), .d_i(convst_b), .q_o(convst_b_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_cs  (.clk(clk), .rst_n(rst_n), .d_i(cs_n),     .q_o(cs_n_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_rd  (.clk(clk), .rst_n(rst_n), .d_i(rd_n),     .q_o(rd_n_s));
  sync2 #(.RST_VAL(1'b0)) u_sync_rst (.clk(clk), .rst_n(rst_n), .d_i(phy_rst),  .q_o(phy_rst_s));

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [OS_W-1:0]  os_q;
  logic [PTR_W-1:0] ptr_q;
  logic             conv_prev_q;
  logic             rd_prev_q;
  bank_t            pend_q;
  bank_t            out_q;

  logic             conv_s_c;
  logic             start_c;
  logic             rd_fall_c;
  logic             rd_rise_c;
  logic [CNT_W-1:0] conv_len_c;
  bank_t            pat_c;
  bank_t            src_c;

  // Edge detection on synchronized pins; starts are masked during device reset.
  assign conv_s_c   = convst_a_s & convst_b_s;
  assign start_c    = conv_prev_q & ~conv_s_c & ~phy_rst_s;
  assign rd_fall_c  = rd_prev_q & ~rd_n_s;
  assign rd_rise_c  = ~rd_prev_q & rd_n_s;
  assign conv_len_c = CNT_W'(CONV_CYCLES) << os_q;

  // Deterministic pattern: conversion index in the upper bits, channel in the low nibble.
  always_comb begin
    pat_c = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      pat_c[k] = {conv_cnt[11:0], 4'(k)};
    end
  end

  assign src_c = (PATTERN != 0) ? pat_c : bank_t'(sample_in);

  // Conversion FSM and read port; device reset is applied last so it overrides all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      os_q        <= '0;
      ptr_q       <= '0;
      conv_prev_q <= 1'b1;
      rd_prev_q   <= 1'b1;
      pend_q      <= '0;
      out_q       <= '0;
      busy        <= 1'b0;
      frstdata    <= 1'b0;
      db          <= '0;
      db_oe       <= 1'b0;
      conv_cnt    <= '0;
      overrun     <= 1'b0;
    end else begin
      conv_prev_q <= conv_s_c;
      rd_prev_q   <= rd_n_s;
      db_oe       <= ~cs_n_s & ~rd_n_s;

      if (rd_fall_c && !cs_n_s) begin
        db       <= out_q[ptr_q];
        frstdata <= (ptr_q == '0);
      end else if (cs_n_s || rd_n_s) begin
        frstdata <= 1'b0;
      end

      if (rd_rise_c && !cs_n_s) begin
        ptr_q <= ptr_q + PTR_W'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (start_c) begin
            state_q <= ST_DLY;
            cnt_q   <= '0;
            pend_q  <= src_c;
            os_q    <= os_eff(os);
          end
        end
        ST_DLY: begin
          if (start_c) overrun <= 1'b1;
          if (cnt_q == CNT_W'(BUSY_DLY - 1)) begin
            state_q <= ST_CONV;
            cnt_q   <= '0;
            busy    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_CONV: begin
          if (start_c) overrun <= 1'b1;
          // busy drops on entry to DONE so it is high for exactly conv_len_c cycles.
          if (cnt_q == conv_len_c - CNT_W'(1)) begin
            state_q <= ST_DONE;
            busy    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          // Overrides any concurrent read-pointer advance above.
          out_q    <= pend_q;
          ptr_q    <= '0;
          conv_cnt <= conv_cnt + CCNT_W'(1);
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      if (phy_rst_s) begin
        state_q  <= ST_IDLE;
        cnt_q    <= '0;
        busy     <= 1'b0;
        ptr_q    <= '0;
        pend_q   <= '0;
        out_q    <= '0;
        conv_cnt <= '0;
        overrun  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ad7606_emu.sv
// Directed bench for ad7606_emu: one pattern-source instance and one
// external-sample instance share every pin.
module tb_ad7606_emu;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         convst_a, convst_b, cs_n, rd_n, phy_rst;
  logic [2:0]   os;
  logic [127:0] sample_in;

  logic         busy, frstdata, db_oe, overrun;
  logic [15:0]  db, conv_cnt;
  logic         x_busy, x_frstdata, x_db_oe, x_overrun;
  logic [15:0]  x_db, x_conv_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  ad7606_emu #(.CONV_CYCLES(32), .BUSY_DLY(2), .PATTERN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .convst_a(convst_a), .convst_b(convst_b),
    .cs_n(cs_n), .rd_n(rd_n), .phy_rst(phy_rst), .os(os), .sample_in(sample_in),
    .busy(busy), .frstdata(frstdata), .db(db), .db_oe(db_oe),
    .conv_cnt(conv_cnt), .overrun(overrun)
  );

  ad7606_emu #(.CONV_CYCLES(32), .BUSY_DLY(2), .PATTERN(0)) u_ext (
    .clk(clk), .rst_n(rst_n), .convst_a(convst_a), .convst_b(convst_b),
    .cs_n(cs_n), .rd_n(rd_n), .phy_rst(phy_rst), .os(os), .sample_in(sample_in),
    .busy(x_busy), .frstdata(x_frstdata), .db(x_db), .db_oe(x_db_oe),
    .conv_cnt(x_conv_cnt), .overrun(x_overrun)
  );

  // One read strobe; samples both instances well after the 3-cycle data latency.
  task automatic rd_word(output logic [15:0] d, output logic f,
                         output logic [15:0] dx, output logic fx, output logic oe);
    @(negedge clk) rd_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    d = db; f = frstdata; dx = x_db; fx = x_frstdata; oe = db_oe;
    @(negedge clk) rd_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Drive a CONVST pulse and return once busy is seen high (bounded).
  task automatic start_conv();
    int n;
    @(negedge clk) begin convst_a = 1'b0; convst_b = 1'b0; end
    repeat (3) @(posedge clk);
    #1 begin convst_a = 1'b1; convst_b = 1'b1; end
    n = 0;
    while (!busy && n < 50) begin @(posedge clk); #1; n++; end
  endtask

  // Cycles until busy falls, bounded so a stuck busy still terminates.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 1000) begin @(posedge clk); #1; n++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; convst_a = 1'b1; convst_b = 1'b1; cs_n = 1'b1; rd_n = 1'b1;
    phy_rst = 1'b0; os = 3'd0;
    for (int k = 0; k < 8; k++) sample_in[k*16 +: 16] = 16'hA000 + 16'(k);
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++; if (busy !== 1'b0)      begin err_cnt++; $display("FAIL rst_busy: got %b exp 0", busy); end
    vec_cnt++; if (frstdata !== 1'b0)  begin err_cnt++; $display("FAIL rst_frstdata: got %b exp 0", frstdata); end
    vec_cnt++; if (db !== 16'h0000)    begin err_cnt++; $display("FAIL rst_db: got %h exp 0000", db); end
    vec_cnt++; if (db_oe !== 1'b0)     begin err_cnt++; $display("FAIL rst_db_oe: got %b exp 0", db_oe); end
    vec_cnt++; if (conv_cnt !== 16'd0) begin err_cnt++; $display("FAIL rst_conv_cnt: got %0d exp 0", conv_cnt); end
    vec_cnt++; if (overrun !== 1'b0)   begin err_cnt++; $display("FAIL rst_overrun: got %b exp 0", overrun); end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_conv_os0();
    logic [15:0] d, dx; logic f, fx, oe; logic b4, b5; int n;
    os = 3'd0;
    @(negedge clk) begin convst_a = 1'b0; convst_b = 1'b0; end
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin convst_a = 1'b1; convst_b = 1'b1; end
      if (i == 4) b4 = busy;
      if (i == 5) b5 = busy;
    end
    vec_cnt++; if (b4 !== 1'b0) begin err_cnt++; $display("FAIL lat_busy_early: got %b exp 0", b4); end
    vec_cnt++; if (b5 !== 1'b1) begin err_cnt++; $display("FAIL lat_busy_rise: got %b exp 1", b5); end
    count_busy(n);
    vec_cnt++; if (n !== 32) begin err_cnt++; $display("FAIL busy_len_os0: got %0d exp 32", n); end
    repeat (2) @(posedge clk); #1;
    vec_cnt++; if (conv_cnt !== 16'd1) begin err_cnt++; $display("FAIL conv_cnt_1: got %0d exp 1", conv_cnt); end
    @(negedge clk) cs_n = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rd_word(d, f, dx, fx, oe);
      vec_cnt++; if (d !== 16'(k)) begin err_cnt++; $display("FAIL os0_rd%0d: got %h exp %h", k, d, 16'(k)); end
      vec_cnt++; if (f !== (k == 0)) begin err_cnt++; $display("FAIL os0_frst%0d: got %b exp %b", k, f, (k == 0)); end
      vec_cnt++; if (oe !== 1'b1) begin err_cnt++; $display("FAIL os0_oe%0d: got %b exp 1", k, oe); end
    end
    vec_cnt++; if (db !== 16'h0007) begin err_cnt++; $display("FAIL db_hold: got %h exp 0007", db); end
    vec_cnt++; if (frstdata !== 1'b0 || db_oe !== 1'b0) begin err_cnt++; $display("FAIL idle_flags: got %b%b exp 00", frstdata, db_oe); end
    @(negedge clk) cs_n = 1'b1;
  endtask

  task automatic test_conv_os2();
    logic [15:0] d, dx; logic f, fx, oe; int n;
    os = 3'd2;
    start_conv();
    os = 3'd0;
    count_busy(n);
    vec_cnt++; if (n !== 128) begin err_cnt++; $display("FAIL busy_len_os2: got %0d exp 128", n); end
    repeat (2) @(posedge clk); #1;
    vec_cnt++; if (conv_cnt !== 16'd2) begin err_cnt++; $display("FAIL conv_cnt_2: got %0d exp 2", conv_cnt); end
    @(negedge clk) cs_n = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rd_word(d, f, dx, fx, oe);
      vec_cnt++; if (d !== 16'h0010 + 16'(k)) begin err_cnt++; $display("FAIL os2_rd%0d: got %h exp %h", k, d, 16'h0010 + 16'(k)); end
    end
    @(negedge clk) cs_n = 1'b1;
  endtask

  task automatic test_overrun();
    int n;
    os = 3'd0;
    start_conv();
    n = 0;
    while (busy && n < 1000) begin
      @(posedge clk); #1; n++;
      if (n == 5) begin convst_a = 1'b0; convst_b = 1'b0; end
      if (n == 8) begin convst_a = 1'b1; convst_b = 1'b1; end
    end
    vec_cnt++; if (n !== 32) begin err_cnt++; $display("FAIL ovr_busy_len: got %0d exp 32", n); end
    vec_cnt++; if (overrun !== 1'b1) begin err_cnt++; $display("FAIL ovr_flag: got %b exp 1", overrun); end
    repeat (60) @(posedge clk); #1;
    vec_cnt++; if (conv_cnt !== 16'd3) begin err_cnt++; $display("FAIL ovr_conv_cnt: got %0d exp 3", conv_cnt); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL ovr_no_restart: got %b exp 0", busy); end
  endtask

  task automatic test_ext_samples();
    logic [15:0] d, dx; logic f, fx, oe;
    logic [15:0] exp_d;
    @(negedge clk) cs_n = 1'b0;
    for (int k = 0; k < 10; k++) begin
      rd_word(d, f, dx, fx, oe);
      exp_d = 16'hA000 + 16'(k % 8);
      vec_cnt++; if (dx !== exp_d) begin err_cnt++; $display("FAIL ext_rd%0d: got %h exp %h", k, dx, exp_d); end
      vec_cnt++; if (fx !== (k % 8 == 0)) begin err_cnt++; $display("FAIL ext_frst%0d: got %b exp %b", k, fx, (k % 8 == 0)); end
    end
    @(negedge clk) cs_n = 1'b1;
  endtask

  task automatic test_read_during_conv();
    logic [15:0] d, dx; logic f, fx, oe; int n;
    @(negedge clk) cs_n = 1'b0;
    for (int k = 0; k < 6; k++) rd_word(d, f, dx, fx, oe);
    for (int k = 0; k < 3; k++) begin
      rd_word(d, f, dx, fx, oe);
      vec_cnt++; if (d !== 16'h0020 + 16'(k)) begin err_cnt++; $display("FAIL pre_rd%0d: got %h exp %h", k, d, 16'h0020 + 16'(k)); end
    end
    start_conv();
    rd_word(d, f, dx, fx, oe);
    vec_cnt++; if (d !== 16'h0023 || f !== 1'b0) begin err_cnt++; $display("FAIL mid_conv_rd: got %h/%b exp 0023/0", d, f); end
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL mid_conv_busy: got %b exp 1", busy); end
    count_busy(n);
    repeat (2) @(posedge clk); #1;
    rd_word(d, f, dx, fx, oe);
    vec_cnt++; if (d !== 16'h0030 || f !== 1'b1) begin err_cnt++; $display("FAIL new_bank_rd: got %h/%b exp 0030/1", d, f); end
    vec_cnt++; if (conv_cnt !== 16'd4) begin err_cnt++; $display("FAIL conv_cnt_4: got %0d exp 4", conv_cnt); end
    @(negedge clk) cs_n = 1'b1;
  endtask

  task automatic test_phy_rst();
    logic [15:0] d, dx; logic f, fx, oe;
    vec_cnt++; if (overrun !== 1'b1) begin err_cnt++; $display("FAIL ovr_sticky: got %b exp 1", overrun); end
    start_conv();
    repeat (10) @(posedge clk); #1;
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL prst_busy_before: got %b exp 1", busy); end
    @(negedge clk) phy_rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL prst_busy_drop: got %b exp 0", busy); end
    repeat (3) @(posedge clk);
    @(negedge clk) phy_rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    vec_cnt++; if (conv_cnt !== 16'd0) begin err_cnt++; $display("FAIL prst_conv_cnt: got %0d exp 0", conv_cnt); end
    vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL prst_overrun: got %b exp 0", overrun); end
    @(negedge clk) cs_n = 1'b0;
    rd_word(d, f, dx, fx, oe);
    vec_cnt++; if (d !== 16'h0000 || f !== 1'b1) begin err_cnt++; $display("FAIL prst_rd0: got %h/%b exp 0000/1", d, f); end
    rd_word(d, f, dx, fx, oe);
    vec_cnt++; if (dx !== 16'h0000) begin err_cnt++; $display("FAIL prst_ext_rd1: got %h exp 0000", dx); end
    @(negedge clk) cs_n = 1'b1;
    repeat (60) @(posedge clk); #1;
    vec_cnt++; if (busy !== 1'b0 || conv_cnt !== 16'd0) begin err_cnt++; $display("FAIL prst_stays_idle: got %b/%0d exp 0/0", busy, conv_cnt); end
  endtask

  initial begin
    test_reset();
    test_conv_os0();
    test_conv_os2();
    test_overrun();
    test_ext_samples();
    test_read_during_conv();
    test_phy_rst();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
